// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: FSM states, frame size
// and the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_e;

  localparam int UART_FRAME_BYTES = 40;

  // Integer division; callers must keep the result >= 2.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period. Held at zero while clear is high.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)     cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_frame_tx.sv
// Frame transmitter: latches an 8*NBYTES-bit frame on send and shifts it out
// as NBYTES back-to-back 8N1 characters, MSB byte first, LSB bit first.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int NBYTES = UART_FRAME_BYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send,
  input  logic [8*NBYTES-1:0] data,
  output logic                send_done,
  output logic                busy,
  output logic                tx
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int W   = 8 * NBYTES;
  localparam int BW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  tx_state_e     state, nstate;
  logic          armed;
  logic [W-1:0]  shreg;
  logic [2:0]    bit_idx;
  logic [BW-1:0] byte_idx;
  logic          tick;
  logic          accept;
  logic [7:0]    cur_byte;

  // Counter is parked at zero between frames so the start bit gets a full period.
  uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear((state == IDLE) || (state == DONE)),
    .tick (tick)
  );

  assign accept   = (state == IDLE) && send && armed;
  assign cur_byte = shreg[W-1 -: 8];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (accept) nstate = START;
      START: if (tick) nstate = DATA;
      DATA:  if (tick && bit_idx == 3'd7) nstate = STOP;
      STOP:  if (tick) nstate = (byte_idx == LAST_BYTE) ? DONE : START;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // armed blocks retriggering until send has been seen low at least once.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if (!send)       armed <= 1'b1;
      else if (accept) armed <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          shreg    <= data;
          byte_idx <= '0;
        end
        START: if (tick) bit_idx <= '0;
        DATA:  if (tick) bit_idx <= bit_idx + 3'd1;
        STOP:  if (tick && byte_idx != LAST_BYTE) begin
          byte_idx <= byte_idx + BW'(1);
          shreg    <= shreg << 8;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx        = 1'b1;
    send_done = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      DONE:    send_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboarded bench for uart_frame_tx: the driver queues expected frames,
// the monitor predicts tx/busy/send_done for every cycle from frame arithmetic.
module tb_uart_frame_tx;

  localparam int CLK_HZ = 400;
  localparam int BAUD   = 100;
  localparam int NB     = 40;
  localparam int CPB    = 4;
  localparam int W      = 8 * NB;
  localparam int FRAME  = NB * 10 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         send = 1'b0;
  logic [W-1:0] data = '0;
  logic         send_done, busy, tx;

  uart_frame_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send),
    .data     (data),
    .send_done(send_done),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           start_q[$];
  logic [W-1:0] frame_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  bit           chk_en = 1'b0;
  bit           cur_act = 1'b0;
  int           cur_start = 0;
  logic [W-1:0] cur_frame = '0;

  // Line level at a given cycle offset from the first start-bit cycle.
  function automatic logic exp_line(input logic [W-1:0] f, input int off);
    int b, slot;
    if (off >= FRAME) return 1'b1;
    b    = off / (10 * CPB);
    slot = (off % (10 * CPB)) / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return f[W - 8 * (b + 1) + slot - 1];
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_tx, e_busy, e_done;
    int   off;
    if (chk_en) begin
      if (!cur_act && start_q.size() > 0 && start_q[0] == cyc) begin
        cur_act   = 1'b1;
        cur_start = start_q.pop_front();
        cur_frame = frame_q.pop_front();
      end
      off    = cyc - cur_start;
      e_tx   = cur_act ? exp_line(cur_frame, off) : 1'b1;
      e_busy = cur_act;
      e_done = cur_act && (off == FRAME);
      check("tx", tx, e_tx);
      check("busy", busy, e_busy);
      check("send_done", send_done, e_done);
      if (e_done) cur_act = 1'b0;
      if (rst) begin
        cur_act = 1'b0;
        start_q.delete();
        frame_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Caller guarantees the DUT is idle and armed, so acceptance is this edge.
  task automatic issue(input logic [W-1:0] d, output int s);
    send = 1'b1;
    data = d;
    s    = cyc + 1;
    start_q.push_back(s);
    frame_q.push_back(d);
  endtask

  function automatic logic [W-1:0] rand_frame();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [W-1:0] f;
    int s;

    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();

    // 39 x 0xFF then 0x01, send held through and long after send_done
    f = {{39{8'hFF}}, 8'h01};
    issue(f, s);
    wait_until(s + FRAME);
    repeat (3000) tick();
    send = 1'b0;
    tick();

    // alternating bytes; data and send disturbed mid-frame
    for (int i = 0; i < NB; i++) f[W - 8 * (i + 1) +: 8] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
    issue(f, s);
    wait_until(s + 100);
    data = rand_frame();
    wait_until(s + 200);
    send = 1'b0;
    wait_until(s + 300);
    send = 1'b1;
    data = rand_frame();
    wait_until(s + 500);
    send = 1'b0;
    data = rand_frame();
    wait_until(s + FRAME + 60);

    // reset pulse at byte 12, bit 3
    issue(rand_frame(), s);
    wait_until(s + 10);
    send = 1'b0;
    wait_until(s + 12 * 10 * CPB + 4 * CPB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // full frame after reset, then send dropped in DONE and re-raised next cycle
    issue(rand_frame(), s);
    wait_until(s + FRAME);
    send = 1'b0;
    tick();
    issue(rand_frame(), s);
    wait_until(s + FRAME);
    send = 1'b0;

    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 30)) tick();
      issue(rand_frame(), s);
      wait_until(s + FRAME);
      send = 1'b0;
    end
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serial transmitter downstream of the UART frame producer: accepts a 320-bit frame on a level `send` request, then shifts it out on `tx` as 40 bytes of 8N1 UART. Asserts a one-cycle `send_done` when the last stop bit completes. Sits between the frame-building logic and the board's serial TX pin.

## Interface

- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = CLK_HZ / BAUD`, integer division, must be ≥ 2.
- `NBYTES`, 40: frame length in bytes; data width is `8*NBYTES`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `send`  in  1  frame request, level; held high by the producer until `send_done`.
- `data`  in  320  frame payload; sampled only on acceptance.
- `send_done`  out  1  one-cycle pulse; frame fully on the line.
- `busy`  out  1  high from the cycle after acceptance through the `send_done` cycle.
- `tx`  out  1  serial line; idles high.

## Operation

- States: IDLE, START, DATA, STOP, DONE.
- IDLE: `tx=1`. Accept when `send=1` and `armed=1`: latch `data` into the shift register, clear the byte index, go to START.
  - `armed` is cleared on acceptance.
  - `armed` is set in any cycle with `send=0`.
  - Effect: a `send` that stays high after `send_done` never retriggers.
- START: `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA: `tx` = current byte bit, LSB first, each bit for `CLKS_PER_BIT` cycles. After bit 7 go to STOP.
- Byte order: `data[319:312]` first, `data[7:0]` last. The shift register shifts left by 8 per byte.
- STOP: `tx=1` for `CLKS_PER_BIT` cycles.
  - If byte index < `NBYTES-1`: increment the index and go to START. No idle gap between bytes.
  - Otherwise go to DONE.
- DONE: single cycle. `send_done=1`, `tx=1`, then go to IDLE.
- `send` and `data` are ignored outside IDLE. Dropping `send` mid-frame does not abort the frame.
- Counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT-1`, wraps to 0 on each bit boundary.
  - Bit index: 3 bits.
  - Byte index: `$clog2(NBYTES)` bits, no wrap beyond `NBYTES-1`.

## Timing

- Reset values: `tx=1`, `send_done=0`, `busy=0`, state IDLE, `armed=1`, counters 0.
- Reset asserted mid-frame: on the next edge `tx=1`, no `send_done`, frame abandoned.
- Acceptance at edge k:
  - `tx` goes low and `busy` goes high from cycle k+1.
  - Start bit of byte 0 occupies cycles k+1 .. k+`CLKS_PER_BIT`.
- Frame length on the line: `NBYTES*10*CLKS_PER_BIT` cycles.
- `send_done` is high in cycle k+1+`NBYTES*10*CLKS_PER_BIT`. `busy` falls the following cycle.
- Earliest re-acceptance: the first IDLE cycle in which `send=1` after at least one cycle of `send=0` (which may be seen during the frame or in DONE).
- If `send` is already low during DONE, the producer may raise it again at any later cycle and is accepted on that edge.

## Structure

- Shared package `uart_pkg`:
  - State enum (IDLE/START/DATA/STOP/DONE).
  - `UART_FRAME_BYTES = 40`.
  - Helper function computing `CLKS_PER_BIT`.
- Sub-module `uart_baud_tick`: counter with `clear` input; emits `tick` on the last cycle of each bit period. The transmitter FSM advances only on `tick`.
- The frame shift register and FSM live in `uart_frame_tx`.

## Test plan

Bench uses `CLK_HZ=400`, `BAUD=100`, giving `CLKS_PER_BIT=4`.

- Reset, then `send=0` for 20 cycles -> `tx=1`, `busy=0`, `send_done=0` throughout.
- `data = 320'h01` in the LSB byte with all other bytes 0xFF, `send` held high until `send_done` -> 40 frames on `tx`:
  - first 39 decode to 0xFF;
  - last decodes to 0x01;
  - start=0 / stop=1 each 4 cycles;
  - `send_done` pulses exactly 1600 cycles after acceptance, once.
- `send` held high for 3000 cycles after `send_done` -> no second start bit; `tx` stays 1.
- Alternating 0xA5/0x5A bytes; `data` changed and `send` toggled mid-frame -> line bits match the latched value; exactly one frame is sent.
- `rst` pulsed for one cycle at byte 12, bit 3 -> `tx=1` next cycle, no `send_done`; a new `send` afterwards transmits a full, correct frame.
- `send` dropped during DONE and raised 1 cycle after -> second frame accepted that edge; the gap between the two frames is 2 idle cycles of `tx=1`.
